// File: rtl/program_sequencer.sv
// program_sequencer
//   Multi-program run controller for the 9-bit CPU family. A rising edge on
//   `start` loads the selected entry point into the core PC. It then enables
//   the core and counts RUN cycles until the core halts, the optional timeout
//   expires or the host aborts. Completion is reported on `done`, either as a
//   level or as a one-cycle pulse.
//
// Parameters
//   PC_W       program counter width
//   NUM_PROGS  number of selectable entry points (>= 1)
//   CYC_W      cycle counter width
//   TIMEOUT    max RUN cycles, 0 disables
//   DONE_MODE  0: level done, 1: one-cycle done pulse
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        launch request (rising edge in IDLE)
//   abort        force-stop a run in LOAD/RUN
//   prog_sel     program index, sampled with the accepted start
//   entry_pcs    packed entry addresses, entry i at [i*PC_W +: PC_W]
//   core_halt    core decoded its halt instruction this cycle
//   pc_load      one-cycle PC load strobe
//   pc_load_val  entry address to load (holds outside LOAD)
//   core_run     core step enable
//   busy         run in progress (LOAD, RUN, FIN)
//   done         run completion
//   timed_out    last run ended by timeout
//   cycles       RUN cycle count of the current or last run
module program_sequencer #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned NUM_PROGS = 4,
  parameter int unsigned CYC_W     = 16,
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned DONE_MODE = 0,
  localparam int unsigned SEL_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [SEL_W-1:0]          prog_sel,
  input  logic [NUM_PROGS*PC_W-1:0] entry_pcs,
  input  logic                      core_halt,
  output logic                      pc_load,
  output logic [PC_W-1:0]           pc_load_val,
  output logic                      core_run,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic [CYC_W-1:0]          cycles
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  logic [1:0]       state;
  logic             start_q;
  logic [SEL_W-1:0] sel_q;
  logic [PC_W-1:0]  pc_val_q;
  logic [PC_W-1:0]  entry_sel;
  logic [CYC_W-1:0] cyc_inc;
  logic             accept;
  logic             timeout_hit;

  assign accept = (state == ST_IDLE) && start && !start_q;

  // Saturating RUN-cycle counter increment.
  assign cyc_inc = (cycles == '1) ? cycles : cycles + CYC_W'(1);

  // `cycles` counts completed RUN cycles, so the current one is cycles+1.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cycles) + 32'd1) == TIMEOUT);

  // Out-of-range indices fall back to entry 0.
  always_comb begin
    entry_sel = entry_pcs[PC_W-1:0];
    for (int unsigned i = 1; i < NUM_PROGS; i++) begin
      if (32'(sel_q) == i) entry_sel = entry_pcs[i*PC_W +: PC_W];
    end
  end

  assign pc_load     = (state == ST_LOAD);
  assign core_run    = (state == ST_RUN);
  assign busy        = (state != ST_IDLE);
  // Live entry during LOAD, last loaded value otherwise.
  assign pc_load_val = pc_load ? entry_sel : pc_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      sel_q     <= '0;
      pc_val_q  <= '0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      cycles    <= '0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sel_q     <= prog_sel;
            done      <= 1'b0;
            timed_out <= 1'b0;
            cycles    <= '0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pc_val_q <= entry_sel;
          state    <= abort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          cycles <= cyc_inc;
          if (abort) begin
            state <= ST_IDLE;
          end else if (core_halt) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ST_FIN;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          if (DONE_MODE != 0) done <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  prog_sel;
  logic [39:0] entry_pcs;
  logic        core_halt;

  logic        pc_load_0, core_run_0, busy_0, done_0, timed_out_0;
  logic [9:0]  pc_load_val_0;
  logic [15:0] cycles_0;
  logic        pc_load_1, core_run_1, busy_1, done_1, timed_out_1;
  logic [9:0]  pc_load_val_1;
  logic [15:0] cycles_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_sequencer #(.PC_W(10), .NUM_PROGS(4), .CYC_W(16), .TIMEOUT(8), .DONE_MODE(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prog_sel(prog_sel),
    .entry_pcs(entry_pcs), .core_halt(core_halt), .pc_load(pc_load_0),
    .pc_load_val(pc_load_val_0), .core_run(core_run_0), .busy(busy_0),
    .done(done_0), .timed_out(timed_out_0), .cycles(cycles_0)
  );

  program_sequencer #(.PC_W(10), .NUM_PROGS(4), .CYC_W(16), .TIMEOUT(8), .DONE_MODE(1)) u_pls (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prog_sel(prog_sel),
    .entry_pcs(entry_pcs), .core_halt(core_halt), .pc_load(pc_load_1),
    .pc_load_val(pc_load_val_1), .core_run(core_run_1), .busy(busy_1),
    .done(done_1), .timed_out(timed_out_1), .cycles(cycles_1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; observe 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    core_halt = 1'b0;
    prog_sel  = 2'd0;
    // entry0=3FF, entry1=200, entry2=080, entry3=010
    entry_pcs = {10'h010, 10'h080, 10'h200, 10'h3FF};

    // Reset state before any clock edge
    #2;
    chk("rst_busy",    32'(busy_0),        32'd0);
    chk("rst_pc_load", 32'(pc_load_0),     32'd0);
    chk("rst_pc_val",  32'(pc_load_val_0), 32'd0);
    chk("rst_run",     32'(core_run_0),    32'd0);
    chk("rst_done",    32'(done_0),        32'd0);
    chk("rst_to",      32'(timed_out_0),   32'd0);
    chk("rst_cycles",  32'(cycles_0),      32'd0);
    tick_n(2);
    rst_n = 1'b1;
    tick();

    // Normal run: prog 2, halt on RUN cycle 5
    prog_sel = 2'd2;
    start = 1'b1;
    tick();                                   // cycle 1 (LOAD)
    start = 1'b0;
    chk("norm_pc_load",  32'(pc_load_0),     32'd1);
    chk("norm_pc_val",   32'(pc_load_val_0), 32'h080);
    chk("norm_run_c1",   32'(core_run_0),    32'd0);
    chk("norm_busy_c1",  32'(busy_0),        32'd1);
    tick();                                   // cycle 2 (RUN 1)
    chk("norm_run_c2",   32'(core_run_0),    32'd1);
    chk("norm_pcl_c2",   32'(pc_load_0),     32'd0);
    chk("norm_pcv_hold", 32'(pc_load_val_0), 32'h080);
    tick_n(4);                                // cycle 6 (RUN 5)
    chk("norm_cyc_c6",   32'(cycles_0),      32'd4);
    chk("norm_done1_c6", 32'(done_1),        32'd0);
    core_halt = 1'b1;
    tick();                                   // cycle 7 (FIN)
    core_halt = 1'b0;
    chk("norm_done0",    32'(done_0),        32'd1);
    chk("norm_done1",    32'(done_1),        32'd1);
    chk("norm_cycles",   32'(cycles_0),      32'd5);
    chk("norm_to",       32'(timed_out_0),   32'd0);
    chk("norm_run_fin",  32'(core_run_0),    32'd0);
    chk("norm_busy_fin", 32'(busy_0),        32'd1);
    tick();                                   // IDLE
    chk("norm_busy_idle", 32'(busy_0),       32'd0);
    chk("lvl_done_hold",  32'(done_0),       32'd1);
    chk("pls_done_drop",  32'(done_1),       32'd0);
    tick_n(2);
    chk("lvl_done_hold2", 32'(done_0),       32'd1);
    chk("idle_cyc_hold",  32'(cycles_0),     32'd5);

    // Timeout: prog 3, no halt
    prog_sel = 2'd3;
    start = 1'b1;
    tick();                                   // LOAD
    start = 1'b0;
    chk("to_pc_val",     32'(pc_load_val_0), 32'h010);
    chk("to_done_clr",   32'(done_0),        32'd0);
    chk("to_cyc_clr",    32'(cycles_0),      32'd0);
    tick();                                   // RUN 1
    tick_n(7);                                // RUN 8
    chk("to_run_r8",     32'(core_run_0),    32'd1);
    chk("to_cyc_r8",     32'(cycles_0),      32'd7);
    tick();                                   // FIN
    chk("to_done",       32'(done_0),        32'd1);
    chk("to_cycles",     32'(cycles_0),      32'd8);
    chk("to_flag",       32'(timed_out_0),   32'd1);
    chk("to_flag_pls",   32'(timed_out_1),   32'd1);
    tick();                                   // IDLE
    chk("to_flag_hold",  32'(timed_out_0),   32'd1);

    // Halt and timeout on the same RUN cycle: halt wins
    prog_sel = 2'd0;
    start = 1'b1;
    tick();                                   // LOAD
    start = 1'b0;
    chk("ht_pc_val",     32'(pc_load_val_0), 32'h3FF);
    chk("ht_to_clr",     32'(timed_out_0),   32'd0);
    tick();                                   // RUN 1
    tick_n(7);                                // RUN 8
    core_halt = 1'b1;
    tick();                                   // FIN
    core_halt = 1'b0;
    chk("ht_done",       32'(done_0),        32'd1);
    chk("ht_cycles",     32'(cycles_0),      32'd8);
    chk("ht_to",         32'(timed_out_0),   32'd0);
    tick();

    // Abort on RUN cycle 3
    prog_sel = 2'd1;
    start = 1'b1;
    tick();                                   // LOAD
    start = 1'b0;
    chk("ab_pc_val",     32'(pc_load_val_0), 32'h200);
    tick();                                   // RUN 1
    tick_n(2);                                // RUN 3
    abort = 1'b1;
    tick();                                   // IDLE
    abort = 1'b0;
    chk("ab_busy",       32'(busy_0),        32'd0);
    chk("ab_done0",      32'(done_0),        32'd0);
    chk("ab_done1",      32'(done_1),        32'd0);
    chk("ab_cycles",     32'(cycles_0),      32'd3);
    chk("ab_run",        32'(core_run_0),    32'd0);
    chk("ab_to",         32'(timed_out_0),   32'd0);

    // Abort in LOAD
    start = 1'b1;
    tick();                                   // LOAD
    chk("abl_pc_load",   32'(pc_load_0),     32'd1);
    abort = 1'b1;
    tick();                                   // IDLE
    abort = 1'b0;
    start = 1'b0;
    chk("abl_busy",      32'(busy_0),        32'd0);
    chk("abl_cycles",    32'(cycles_0),      32'd0);
    chk("abl_run",       32'(core_run_0),    32'd0);
    tick();
    chk("abl_run2",      32'(core_run_0),    32'd0);
    chk("abl_pcl2",      32'(pc_load_0),     32'd0);

    // Held start with extra edges during RUN
    prog_sel = 2'd2;
    start = 1'b1;
    tick();                                   // LOAD
    tick();                                   // RUN 1
    start = 1'b0;
    tick();                                   // RUN 2
    start = 1'b1;
    tick();                                   // RUN 3
    chk("hs_pcl_run",    32'(pc_load_0),     32'd0);
    core_halt = 1'b1;
    tick();                                   // FIN
    core_halt = 1'b0;
    chk("hs_done",       32'(done_0),        32'd1);
    chk("hs_cycles",     32'(cycles_0),      32'd3);
    tick();                                   // IDLE, start still high
    chk("hs_busy_idle",  32'(busy_0),        32'd0);
    tick_n(2);
    chk("hs_no_relaunch", 32'(busy_0),       32'd0);
    chk("hs_no_pcl",     32'(pc_load_0),     32'd0);
    chk("hs_done_hold",  32'(done_0),        32'd1);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();                                   // LOAD of second run
    start = 1'b0;
    chk("hs_relaunch",   32'(pc_load_0),     32'd1);
    chk("hs_done_clr",   32'(done_0),        32'd0);
    tick();                                   // RUN 1
    core_halt = 1'b1;
    tick();                                   // FIN (minimum latency)
    core_halt = 1'b0;
    chk("min_done",      32'(done_0),        32'd1);
    chk("min_cycles",    32'(cycles_0),      32'd1);
    tick();

    // Reset mid-RUN, asynchronously, with start held through release
    start = 1'b1;
    tick();                                   // LOAD
    start = 1'b0;
    tick();                                   // RUN 1
    tick();                                   // RUN 2
    chk("mr_run_pre",    32'(core_run_0),    32'd1);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("mr_busy",       32'(busy_0),        32'd0);
    chk("mr_run",        32'(core_run_0),    32'd0);
    chk("mr_pc_val",     32'(pc_load_val_0), 32'd0);
    chk("mr_cycles",     32'(cycles_0),      32'd0);
    chk("mr_done",       32'(done_0),        32'd0);
    tick();
    chk("mr_hold_busy",  32'(busy_0),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();                                   // first edge after release
    chk("mr_launch",     32'(pc_load_0),     32'd1);
    chk("mr_launch_val", 32'(pc_load_val_0), 32'h080);
    start = 1'b0;
    tick();                                   // RUN 1
    chk("mr_run_after",  32'(core_run_0),    32'd1);
    tick();                                   // RUN 2
    core_halt = 1'b1;
    tick();                                   // FIN
    core_halt = 1'b0;
    chk("mr_done_after", 32'(done_0),        32'd1);
    chk("mr_cyc_after",  32'(cycles_0),      32'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
